// File: rtl/exec_pkg.sv
// Shared encodings for the execute/write-back stage: ALU ops, B-operand shifts and FSM states.
package exec_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_MVN = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } sh_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_B = 3'd1,
    RD_A = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_e;

endpackage

// File: rtl/exec_alu.sv
// Combinational shifter + ALU: shifts B by one place, computes the result and its z/n/v flags.
module exec_alu
  import exec_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  op_e          op,
  input  sh_e          shift,
  output logic [W-1:0] result,
  output logic         z,
  output logic         n,
  output logic         v
);

  logic [W-1:0] bs;

  always_comb begin
    bs = b;
    unique case (shift)
      SH_NONE: bs = b;
      SH_LSL:  bs = {b[W-2:0], 1'b0};
      SH_LSR:  bs = {1'b0, b[W-1:1]};
      SH_ASR:  bs = {b[W-1], b[W-1:1]};
      default: bs = b;
    endcase
  end

  always_comb begin
    result = '0;
    v      = 1'b0;
    unique case (op)
      OP_ADD: begin
        result = a + bs;
        v      = (a[W-1] == bs[W-1]) && (result[W-1] != a[W-1]);
      end
      OP_SUB: begin
        result = a - bs;
        v      = (a[W-1] != bs[W-1]) && (result[W-1] != a[W-1]);
      end
      OP_AND:  result = a & bs;
      OP_MVN:  result = ~bs;
      default: result = '0;
    endcase
  end

  assign z = (result == '0);
  assign n = result[W-1];

endmodule

// File: rtl/exec_stage.sv
// Multi-cycle execute/write-back stage: reads Rm then Rn from the regfile, runs the ALU,
// updates flags and writes Rd (unless cmp). Fixed four cycles of busy per command.
module exec_stage #(
  parameter int unsigned W  = 16,
  parameter int unsigned RA = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [1:0]    shift,
  input  logic          cmp,
  input  logic [RA-1:0] rn,
  input  logic [RA-1:0] rm,
  input  logic [RA-1:0] rd,
  input  logic [W-1:0]  rdata,
  output logic [RA-1:0] readnum,
  output logic [RA-1:0] writenum,
  output logic          write,
  output logic [W-1:0]  wdata,
  output logic          busy,
  output logic          done,
  output logic          z,
  output logic          n,
  output logic          v
);
  import exec_pkg::*;

  state_e        state_q;
  op_e           op_q;
  sh_e           shift_q;
  logic          cmp_q;
  logic [RA-1:0] rn_q, rm_q, rd_q;
  logic [W-1:0]  a_q, b_q, c_q;
  logic          z_q, n_q, v_q;

  logic [W-1:0]  alu_result;
  logic          alu_z, alu_n, alu_v;

  exec_alu #(
    .W(W)
  ) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .shift  (shift_q),
    .result (alu_result),
    .z      (alu_z),
    .n      (alu_n),
    .v      (alu_v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      shift_q <= SH_NONE;
      cmp_q   <= 1'b0;
      rn_q    <= '0;
      rm_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op_e'(op);
            shift_q <= sh_e'(shift);
            cmp_q   <= cmp;
            rn_q    <= rn;
            rm_q    <= rm;
            rd_q    <= rd;
            state_q <= RD_B;
          end
        end
        RD_B: begin
          b_q     <= rdata;
          state_q <= RD_A;
        end
        RD_A: begin
          a_q     <= rdata;
          state_q <= EXEC;
        end
        EXEC: begin
          c_q     <= alu_result;
          z_q     <= alu_z;
          n_q     <= alu_n;
          v_q     <= alu_v;
          state_q <= WB;
        end
        WB:      state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state only, so they never glitch on input changes.
  always_comb begin
    readnum = '0;
    unique case (state_q)
      RD_B:    readnum = rm_q;
      RD_A:    readnum = rn_q;
      default: readnum = '0;
    endcase
  end

  assign done     = (state_q == WB);
  assign write    = done & ~cmp_q;
  assign writenum = write ? rd_q : '0;
  assign wdata    = done ? c_q : '0;
  assign busy     = (state_q != IDLE);
  assign z        = z_q;
  assign n        = n_q;
  assign v        = v_q;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage with a behavioural 8x16 register file on its read/write ports.
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op, sh;
  logic        cmp;
  logic [2:0]  rn, rm, rd;
  logic [15:0] rdata;
  logic [2:0]  readnum, writenum;
  logic        write;
  logic [15:0] wdata;
  logic        busy, done, z, n, v;

  logic [15:0] regs [8];
  logic        pre_we = 1'b0;
  logic [2:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  int          wr_count = 0;
  int          done_count = 0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  exec_stage #(
    .W  (16),
    .RA (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .shift    (sh),
    .cmp      (cmp),
    .rn       (rn),
    .rm       (rm),
    .rd       (rd),
    .rdata    (rdata),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .z        (z),
    .n        (n),
    .v        (v)
  );

  assign rdata = regs[readnum];

  always @(posedge clk) begin
    if (write) begin
      regs[writenum] <= wdata;
      wr_count       <= wr_count + 1;
    end
    if (pre_we) regs[pre_addr] <= pre_data;
    if (done) done_count <= done_count + 1;
  end

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  sh;
    logic        cmp;
    logic [2:0]  rn, rm, rd;
    logic [15:0] a, b, res;
    logic        z, n, v;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; returns at a negedge with the DUT idle.
  task automatic preload(input logic [2:0] addr, input logic [15:0] data);
    pre_we = 1'b1; pre_addr = addr; pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Caller is at a negedge with the DUT idle; returns at the IDLE negedge after WB.
  task automatic run_cmd(input vec_t t, input string tag);
    int wc;
    wc = wr_count;
    op = t.op; sh = t.sh; cmp = t.cmp; rn = t.rn; rm = t.rm; rd = t.rd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy"}, 16'(busy), 16'd1);
    check({tag, " readnum_rm"}, 16'(readnum), 16'(t.rm));
    @(negedge clk);
    check({tag, " readnum_rn"}, 16'(readnum), 16'(t.rn));
    @(negedge clk);
    check({tag, " early_done"}, 16'(done), 16'd0);
    @(negedge clk);
    check({tag, " done"}, 16'(done), 16'd1);
    check({tag, " write"}, 16'(write), 16'(!t.cmp));
    check({tag, " writenum"}, 16'(writenum), t.cmp ? 16'd0 : 16'(t.rd));
    check({tag, " wdata"}, wdata, t.res);
    check({tag, " znv"}, {13'd0, z, n, v}, {13'd0, t.z, t.n, t.v});
    @(negedge clk);
    check({tag, " idle"}, {14'd0, busy, done}, 16'd0);
    if (t.cmp) check({tag, " no_write"}, 16'(wr_count - wc), 16'd0);
    else check({tag, " reg_rd"}, regs[t.rd], t.res);
  endtask

  initial begin
    int wc, dc;
    vec_t t;
    //           op    sh    cmp   rn    rm    rd    A         B         result    z     n     v
    vecs[0] = '{2'd0, 2'd0, 1'b0, 3'd1, 3'd2, 3'd3, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'd1, 2'd1, 1'b0, 3'd0, 3'd1, 3'd2, 16'h8000, 16'h0001, 16'h7FFE, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{2'd1, 2'd0, 1'b1, 3'd4, 3'd5, 3'd6, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{2'd3, 2'd3, 1'b0, 3'd1, 3'd6, 3'd5, 16'hFFFF, 16'h8002, 16'h3FFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{2'd2, 2'd2, 1'b0, 3'd2, 3'd3, 3'd4, 16'h00F0, 16'h01E1, 16'h00F0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{2'd0, 2'd0, 1'b0, 3'd3, 3'd4, 3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{2'd2, 2'd0, 1'b0, 3'd5, 3'd6, 3'd7, 16'hFF00, 16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{2'd0, 2'd1, 1'b0, 3'd6, 3'd7, 3'd1, 16'hFFFF, 16'h8000, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{2'd1, 2'd0, 1'b0, 3'd7, 3'd0, 3'd2, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{2'd3, 2'd0, 1'b0, 3'd2, 3'd1, 3'd4, 16'h1111, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = '0; sh = '0; cmp = 1'b0; rn = '0; rm = '0; rd = '0;
    repeat (2) @(negedge clk);
    check("reset busy_done_write", {13'd0, busy, done, write}, 16'd0);
    check("reset readnum_writenum", {10'd0, readnum, 3'd0, writenum}, 16'd0);
    check("reset wdata", wdata, 16'd0);
    check("reset znv", {13'd0, z, n, v}, 16'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) preload(3'(i), 16'h0000);

    for (int i = 0; i < 10; i++) begin
      preload(vecs[i].rn, vecs[i].a);
      preload(vecs[i].rm, vecs[i].b);
      run_cmd(vecs[i], $sformatf("vec%0d", i));
    end

    // Async reset during EXEC: flags are non-zero going in, and R3 must never be written.
    preload(3'd1, 16'h0005);
    preload(3'd2, 16'h0003);
    preload(3'd3, 16'hAAAA);
    check("pre_reset n", 16'(n), 16'd1);
    wc = wr_count;
    op = 2'd0; sh = 2'd0; cmp = 1'b0; rn = 3'd1; rm = 3'd2; rd = 3'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset busy_done_write", {13'd0, busy, done, write}, 16'd0);
    check("midreset znv", {13'd0, z, n, v}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midreset no_write", 16'(wr_count - wc), 16'd0);
    check("midreset r3_kept", regs[3], 16'hAAAA);
    preload(vecs[0].rn, vecs[0].a);
    preload(vecs[0].rm, vecs[0].b);
    run_cmd(vecs[0], "after_reset");

    // start pulsed during RD_A must be dropped, not queued.
    preload(3'd6, 16'h8002);
    preload(3'd5, 16'h0000);
    dc = done_count;
    op = 2'd3; sh = 2'd3; cmp = 1'b0; rn = 3'd1; rm = 3'd6; rd = 3'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("busy_start done_count", 16'(done_count - dc), 16'd1);
    check("busy_start r5", regs[5], 16'h3FFE);
    check("busy_start idle", 16'(busy), 16'd0);

    // Back-to-back with rd == rn == rm: each command sees the previous write.
    preload(3'd7, 16'h0001);
    t = '{2'd0, 2'd0, 1'b0, 3'd7, 3'd7, 3'd7, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0};
    run_cmd(t, "b2b_1");
    t.res = 16'h0004;
    run_cmd(t, "b2b_2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
